pwm_fade_ctrl: RTL

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: drives a PWM instance so its duty cycle ramps from 0 to full,
// holds, ramps back to 0, holds, and repeats while enabled.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_enable         1 runs the fade, 0 returns to IDLE at once
//   i_cfg_valid      qualifies i_top/i_step/i_hold (accepted in IDLE only)
//   i_top            PWM period minus one
//   i_step           compare change per PWM cycle
//   i_hold           extra PWM cycles spent at each extreme
//   i_cycle_end      end-of-period pulse from the PWM instance
//   o_top            top value to the PWM instance
//   o_top_valid      one-cycle pulse: o_top is new
//   o_compare        compare value to the PWM instance (0 .. top+1)
//   o_compare_valid  one-cycle pulse: o_compare changed
//   o_busy           1 in every state except IDLE
//
// state     | meaning
// IDLE      | stopped, compare 0, configuration writes accepted
// RAMP_UP   | compare += step per PWM cycle, saturating at top+1
// HOLD_HIGH | compare held at top+1 for hold+1 PWM cycles
// RAMP_DOWN | compare -= step per PWM cycle, saturating at 0
// HOLD_LOW  | compare held at 0 for hold+1 PWM cycles

module pwm_fade_ctrl #(
   parameter int RESOLUTION = 8,
   parameter int HOLD_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_cfg_valid,
   input  logic [RESOLUTION-1:0] i_top,
   input  logic [RESOLUTION-1:0] i_step,
   input  logic [HOLD_WIDTH-1:0] i_hold,
   input  logic                  i_cycle_end,
   output logic [RESOLUTION-1:0] o_top,
   output logic                  o_top_valid,
   output logic [RESOLUTION:0]   o_compare,
   output logic                  o_compare_valid,
   output logic                  o_busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HIGH = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LOW  = 3'd4
   } state_t;

   localparam logic [RESOLUTION:0]   CMP_ONE  = 1;
   localparam logic [RESOLUTION-1:0] STEP_ONE = 1;
   localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = 1;

   state_t                state_q, state_d;
   logic [RESOLUTION-1:0] top_q, top_d;
   logic [RESOLUTION-1:0] step_q, step_d;
   logic [HOLD_WIDTH-1:0] hold_q, hold_d;
   logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
   logic [RESOLUTION:0]   cmp_q, cmp_d;
   logic                  top_vld_q, top_vld_d;
   logic                  cmp_vld_q, cmp_vld_d;
   // Set while in reset so the first cycle out of reset re-announces
   // both top and compare to the PWM instance.
   logic                  resync_q;

   logic [RESOLUTION:0]   cmp_max;
   logic [RESOLUTION:0]   step_ext;
   logic [RESOLUTION+1:0] sum_up;

   // Extra headroom bit so top+1 plus a large step never wraps.
   assign cmp_max  = {1'b0, top_q} + CMP_ONE;
   assign step_ext = {1'b0, step_q};
   assign sum_up   = {1'b0, cmp_q} + {2'b00, step_q};

   always_comb begin
      state_d    = state_q;
      top_d      = top_q;
      step_d     = step_q;
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      cmp_d      = cmp_q;
      top_vld_d  = resync_q;
      cmp_vld_d  = resync_q;

      if (state_q == IDLE) begin
         // A write wins over a start; the start is re-evaluated next cycle
         // against the freshly latched step.
         if (i_cfg_valid) begin
            top_d     = i_top;
            step_d    = i_step;
            hold_d    = i_hold;
            top_vld_d = 1'b1;
         end else if (i_enable && (step_q != '0)) begin
            state_d = RAMP_UP;
         end
      end else if (!i_enable) begin
         state_d   = IDLE;
         cmp_d     = '0;
         cmp_vld_d = 1'b1;
      end else if (i_cycle_end) begin
         unique case (state_q)
            RAMP_UP: begin
               if (sum_up >= {1'b0, cmp_max}) begin
                  cmp_d      = cmp_max;
                  state_d    = HOLD_HIGH;
                  hold_cnt_d = hold_q;
               end else begin
                  cmp_d = sum_up[RESOLUTION:0];
               end
            end
            HOLD_HIGH: begin
               if (hold_cnt_q == '0) state_d = RAMP_DOWN;
               else                  hold_cnt_d = hold_cnt_q - HOLD_ONE;
            end
            RAMP_DOWN: begin
               if (cmp_q <= step_ext) begin
                  cmp_d      = '0;
                  state_d    = HOLD_LOW;
                  hold_cnt_d = hold_q;
               end else begin
                  cmp_d = cmp_q - step_ext;
               end
            end
            HOLD_LOW: begin
               if (hold_cnt_q == '0) state_d = RAMP_UP;
               else                  hold_cnt_d = hold_cnt_q - HOLD_ONE;
            end
            default: state_d = IDLE;
         endcase
         if (cmp_d != cmp_q) cmp_vld_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         top_q      <= '1;
         step_q     <= STEP_ONE;
         hold_q     <= '0;
         hold_cnt_q <= '0;
         cmp_q      <= '0;
         top_vld_q  <= 1'b0;
         cmp_vld_q  <= 1'b0;
         resync_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         top_q      <= top_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
         cmp_q      <= cmp_d;
         top_vld_q  <= top_vld_d;
         cmp_vld_q  <= cmp_vld_d;
         resync_q   <= 1'b0;
      end
   end

   assign o_top           = top_q;
   assign o_top_valid     = top_vld_q;
   assign o_compare       = cmp_q;
   assign o_compare_valid = cmp_vld_q;
   assign o_busy          = (state_q != IDLE);

endmodule
